wide_add_seq: RTL

Multi-precision add/subtract sequencer that time-shares one 32-bit `p_adder` instance to compute NWORDS×32-bit sums. It processes one word per cycle, least-significant word first, and chains the carry through a register between words. Operands arrive and results leave over valid/ready handshakes. It sits between the operand-producing logic and any wide-arithmetic consumer, so no NWORDS×32-bit adder has to be built.

---
 rtl/wide_add_pkg.sv | 13 +
 rtl/p_adder.sv | 15 +
 rtl/wide_add_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// Shared constants and types for the multi-precision add/subtract sequencer.
package wide_add_pkg;

   // Width of the shared word adder.
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } wa_state_t;

endpackage

// File: rtl/p_adder.sv
// Combinational 32-bit adder with carry-in and carry-out.
module p_adder
   import wide_add_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] s,
   output logic              cout
);

   // One extra bit captures the carry out of the top position.
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 32-bit adder, one word per cycle,
// least-significant word first, carry chained through a register.
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int unsigned NWORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NWORDS*WORD_W-1:0] a,
   input  logic [NWORDS*WORD_W-1:0] b,
   input  logic                     cin,
   input  logic                     sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NWORDS*WORD_W-1:0] sum,
   output logic                     cout,
   output logic                     ovf,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(NWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   wa_state_t state_q, state_d;

   logic [NWORDS*WORD_W-1:0] a_q, b_q, sum_q;
   logic                     carry_q;
   logic                     ovf_q;
   logic [IDX_W-1:0]         idx_q;

   logic [WORD_W-1:0] add_a, add_b, add_s;
   logic              add_cout;
   logic              last_word;

   // b_q already holds ~b for a subtract, so one adder serves both operations.
   assign add_a     = a_q[idx_q*WORD_W +: WORD_W];
   assign add_b     = b_q[idx_q*WORD_W +: WORD_W];
   assign last_word = (idx_q == LAST_IDX);

   p_adder u_p_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = RUN;
         RUN:  if (last_word) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture and per-word accumulation of the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               sum_q[idx_q*WORD_W +: WORD_W] <= add_s;
               carry_q                       <= add_cout;
               if (last_word) begin
                  // Overflow: same-signed operands produced a differently-signed top word.
                  ovf_q <= (add_a[WORD_W-1] == add_b[WORD_W-1]) &&
                           (add_s[WORD_W-1] != add_a[WORD_W-1]);
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = carry_q;
   assign ovf  = ovf_q;

endmodule
